// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Fetch-lookup and execute-update signal bundle for the
//               branch_predictor block. The master side drives the fetch PC
//               and resolved-branch updates. The slave side is the predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;
  // Fetch-stage lookup
  logic [31:0] IF_pc;
  logic        IF_BTBhit;
  logic [1:0]  IF_branch_prediction;
  logic [31:0] IF_pc_imm;
  logic [1:0]  IF_type;
  // Execute-stage resolution
  logic        EX_update;
  logic [31:0] EX_pc;
  logic [1:0]  EX_type;
  logic        EX_taken;
  logic [31:0] EX_target;
  logic        EX_call;

  modport master (
    output IF_pc, EX_update, EX_pc, EX_type, EX_taken, EX_target, EX_call,
    input  IF_BTBhit, IF_branch_prediction, IF_pc_imm, IF_type
  );

  modport slave (
    input  IF_pc, EX_update, EX_pc, EX_type, EX_taken, EX_target, EX_call,
    output IF_BTBhit, IF_branch_prediction, IF_pc_imm, IF_type
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               direction counters and zero-latency lookup. An optional
//               return address stack is compiled in when the macro
//               BRANCH_PREDICTOR_RAS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int ENTRIES   = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  // Table state: valid bits and counters are reset, the payload is not
  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [31:0]        tgt_q  [ENTRIES];
  logic [1:0]         type_q [ENTRIES];

  // Address decomposition for the lookup and update ports
  logic [IDX-1:0]   rd_idx;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             rd_hit;
  logic             wr_hit;
  logic             wr_en;
  logic [1:0]       ctr_d;
  logic [31:0]      btb_imm;

  assign rd_idx = bp.IF_pc[IDX+1:2];
  assign rd_tag = bp.IF_pc[31:IDX+2];
  assign wr_idx = bp.EX_pc[IDX+1:2];
  assign wr_tag = bp.EX_pc[31:IDX+2];

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // A not-taken miss leaves the table alone; everything else writes
  assign wr_en = bp.EX_update && (wr_hit || bp.EX_taken);

  // Next counter value: saturating step on a hit, weakly-taken on allocate
  always_comb begin
    ctr_d = ctr_q[wr_idx];
    if (!wr_hit) begin
      ctr_d = 2'b10;
    end else if (bp.EX_taken) begin
      if (ctr_q[wr_idx] != 2'b11) ctr_d = ctr_q[wr_idx] + 2'b01;
    end else begin
      if (ctr_q[wr_idx] != 2'b00) ctr_d = ctr_q[wr_idx] - 2'b01;
    end
  end

  // Valid bits and counters; reset wins over a simultaneous update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= ctr_d;
    end
  end

  // Tag, target and type payload; an update during reset is discarded
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      tgt_q[wr_idx]  <= bp.EX_target;
      type_q[wr_idx] <= bp.EX_type;
    end
  end

  assign bp.IF_BTBhit            = rd_hit;
  assign bp.IF_branch_prediction = rd_hit ? ctr_q[rd_idx]  : 2'b00;
  assign bp.IF_type              = rd_hit ? type_q[rd_idx] : 2'b00;
  assign btb_imm                 = rd_hit ? tgt_q[rd_idx]  : 32'd0;

`ifdef BRANCH_PREDICTOR_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  // Circular stack: sp_q is the next free slot, cnt_q the live occupancy
  logic [31:0]      ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] top_idx;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_empty;
  logic [31:0]      ret_addr;
  logic             unused_bits;

  assign ras_push  = bp.EX_update && bp.EX_call;
  assign ras_pop   = bp.EX_update && (bp.EX_type == 2'b10);
  assign ras_empty = (cnt_q == '0);
  assign top_idx   = sp_q - PTR_W'(1);
  assign ret_addr  = {bp.EX_pc[31:2] + 30'd1, 2'b00};

  // Pointer and occupancy; a push+pop pair on a live stack only rewrites the top
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (ras_push && ras_pop && !ras_empty) begin
      sp_q  <= sp_q;
      cnt_q <= cnt_q;
    end else if (ras_push) begin
      sp_q  <= sp_q + PTR_W'(1);
      cnt_q <= (cnt_q == RAS_FULL) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (ras_pop && !ras_empty) begin
      sp_q  <= sp_q - PTR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Stack storage; wrapping on overflow naturally overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (ras_push && ras_pop && !ras_empty) ras_q[top_idx] <= ret_addr;
      else if (ras_push)                     ras_q[sp_q]    <= ret_addr;
    end
  end

  assign bp.IF_pc_imm = (rd_hit && (type_q[rd_idx] == 2'b10) && !ras_empty)
                        ? ras_q[top_idx] : btb_imm;
  assign unused_bits  = ^{bp.IF_pc[1:0], bp.EX_pc[1:0]};
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_bits;

  assign bp.IF_pc_imm = btb_imm;
  assign unused_bits  = ^{bp.IF_pc[1:0], bp.EX_pc[1:0], bp.EX_call};
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor: directed scenarios
//               followed by random traffic compared against a behavioural
//               table/queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int ENTRIES   = 64;
  localparam int RAS_DEPTH = 2;
  localparam int IDX       = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(.ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  // Behavioural model
  bit          m_valid [ENTRIES];
  bit [31:0]   m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit [31:0]   m_tgt   [ENTRIES];
  bit [1:0]    m_type  [ENTRIES];
  bit [31:0]   m_ras   [$];

  // Observations sampled mid-cycle
  logic        obs_hit;
  logic [1:0]  obs_pred;
  logic [31:0] obs_imm;
  logic [1:0]  obs_type;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  function automatic int idx_of(input bit [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit [31:0] tag_of(input bit [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_ras.delete();
  endtask

  task automatic model_expect(input bit [31:0] pc, output bit hit, output bit [1:0] ctr,
                              output bit [31:0] imm, output bit [1:0] ty);
    int i;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    ctr = hit ? 2'(m_ctr[i]) : 2'b00;
    ty  = hit ? m_type[i] : 2'b00;
    imm = hit ? m_tgt[i] : 32'd0;
`ifdef BRANCH_PREDICTOR_RAS_EN
    if (hit && ty == 2'b10 && m_ras.size() > 0) imm = m_ras[m_ras.size()-1];
`endif
  endtask

  task automatic model_update(input bit [31:0] pc, input bit [1:0] ty, input bit tk,
                              input bit [31:0] tgt, input bit call);
    int i;
    bit hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (hit) begin
      m_tgt[i]  = tgt;
      m_type[i] = ty;
      if (tk) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(pc);
      m_tgt[i]   = tgt;
      m_type[i]  = ty;
      m_ctr[i]   = 2;
    end
`ifdef BRANCH_PREDICTOR_RAS_EN
    begin
      bit [31:0] ret;
      ret = (pc & ~32'd3) + 32'd4;
      if (call && ty == 2'b10 && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = ret;
      end else begin
        if (ty == 2'b10 && m_ras.size() > 0) void'(m_ras.pop_back());
        if (call) begin
          m_ras.push_back(ret);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
      end
    end
`endif
  endtask

  // One clock: drive at negedge, compare mid-cycle, then advance the model at posedge
  task automatic cycle(input bit rn, input bit [31:0] ifpc, input bit upd,
                       input bit [31:0] expc, input bit [1:0] ety, input bit etk,
                       input bit [31:0] etgt, input bit ecall);
    bit        e_hit;
    bit [1:0]  e_ctr;
    bit [31:0] e_imm;
    bit [1:0]  e_ty;
    @(negedge clk);
    rst_n              = rn;
    bp_if.IF_pc        = ifpc;
    bp_if.EX_update    = upd;
    bp_if.EX_pc        = expc;
    bp_if.EX_type      = ety;
    bp_if.EX_taken     = etk;
    bp_if.EX_target    = etgt;
    bp_if.EX_call      = ecall;
    #1;
    obs_hit  = bp_if.IF_BTBhit;
    obs_pred = bp_if.IF_branch_prediction;
    obs_imm  = bp_if.IF_pc_imm;
    obs_type = bp_if.IF_type;
    if (checking) begin
      model_expect(ifpc, e_hit, e_ctr, e_imm, e_ty);
      check("hit",  32'(obs_hit),  32'(e_hit));
      check("pred", 32'(obs_pred), 32'(e_ctr));
      check("imm",  obs_imm,       e_imm);
      check("type", 32'(obs_type), 32'(e_ty));
    end
    @(posedge clk);
    if (!rn) begin
      model_reset();
      checking = 1'b1;
    end else if (upd) begin
      model_update(expc, ety, etk, etgt, ecall);
    end
  endtask

  task automatic look(input bit [31:0] pc);
    cycle(1'b1, pc, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input bit [31:0] ifpc, input bit [31:0] pc, input bit [1:0] ty,
                     input bit tk, input bit [31:0] tgt, input bit call);
    cycle(1'b1, ifpc, 1'b1, pc, ty, tk, tgt, call);
  endtask

  function automatic bit [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << (IDX + 2)) |
           (32'($urandom_range(0, 7)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  bit        r_rn;
  bit        r_upd;
  bit [1:0]  r_ty;
  bit        r_tk;
  bit        r_call;

  initial begin
    // Reset with a concurrent update that must be discarded
    cycle(1'b0, 32'h100, 1'b1, 32'h100, 2'b00, 1'b1, 32'h200, 1'b0);
    cycle(1'b0, 32'h100, 1'b1, 32'h100, 2'b00, 1'b1, 32'h200, 1'b0);

    // Miss right after reset release
    look(32'h100);
    check("rst_hit", 32'(obs_hit), 32'd0);
    check("rst_imm", obs_imm, 32'd0);

    // Allocate on a taken branch
    upd(32'h100, 32'h100, 2'b00, 1'b1, 32'h200, 1'b0);
    look(32'h100);
    check("alloc_hit",  32'(obs_hit),  32'd1);
    check("alloc_pred", 32'(obs_pred), 32'd2);
    check("alloc_imm",  obs_imm,       32'h200);

    // Saturate up, then down; entry stays valid
    for (int k = 0; k < 3; k++) upd(32'h100, 32'h100, 2'b00, 1'b1, 32'h200, 1'b0);
    look(32'h100);
    check("sat_hi", 32'(obs_pred), 32'd3);
    for (int k = 0; k < 4; k++) upd(32'h100, 32'h100, 2'b00, 1'b0, 32'h200, 1'b0);
    look(32'h100);
    check("sat_lo",     32'(obs_pred), 32'd0);
    check("sat_lo_hit", 32'(obs_hit),  32'd1);

    // Same-index conflict evicts the previous occupant
    upd(32'h100, 32'h200, 2'b00, 1'b1, 32'h400, 1'b0);
    look(32'h100);
    check("evict_old", 32'(obs_hit), 32'd0);
    look(32'h200);
    check("evict_new", 32'(obs_hit), 32'd1);

    // Same-cycle lookup and update return old contents
    upd(32'h300, 32'h300, 2'b01, 1'b1, 32'h800, 1'b0);
    check("bypass_old", 32'(obs_hit), 32'd0);
    look(32'h300);
    check("bypass_new", 32'(obs_hit), 32'd1);
    check("bypass_ty",  32'(obs_type), 32'd1);

`ifdef BRANCH_PREDICTOR_RAS_EN
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    upd(32'h0, 32'h80, 2'b10, 1'b1, 32'h900, 1'b0);
    upd(32'h0, 32'h10, 2'b01, 1'b1, 32'h1000, 1'b1);
    upd(32'h0, 32'h20, 2'b01, 1'b1, 32'h1000, 1'b1);
    upd(32'h0, 32'h30, 2'b01, 1'b1, 32'h1000, 1'b1);
    upd(32'h80, 32'h80, 2'b10, 1'b1, 32'h900, 1'b0);
    check("ras_pop0", obs_imm, 32'h34);
    upd(32'h80, 32'h80, 2'b10, 1'b1, 32'h900, 1'b0);
    check("ras_pop1", obs_imm, 32'h24);
    look(32'h80);
    check("ras_empty", obs_imm, 32'h900);
`endif

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      r_rn   = ($urandom_range(0, 49) != 0);
      r_upd  = ($urandom_range(0, 3) != 0);
      r_ty   = 2'($urandom_range(0, 2));
      r_tk   = (r_ty != 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
      r_call = (r_ty == 2'b01) ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle(r_rn, rand_pc(), r_upd, rand_pc(), r_ty, r_tk, $urandom, r_call);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
